// File: rtl/pe_spad_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : pe_spad_pkg                                            |
// | Shared PE scratchpad widths, word-width helper and terminator.   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package pe_spad_pkg;

   localparam int C_DATA_W = 8;
   localparam int C_CNT_W  = 4;

   function automatic int word_w(input int data_w, input int cnt_w);
      return data_w + cnt_w;
   endfunction

   // An all-zero {data, count} word marks the end of a CSC column set.
   localparam logic [C_DATA_W+C_CNT_W-1:0] C_TERMINATOR = '0;

endpackage
`default_nettype wire

// File: rtl/spad_bank_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : spad_bank_mem                                          |
// | One scratchpad bank: DEPTH x WORD_W, sync write, async read.     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module spad_bank_mem #(
   parameter int WORD_W = 12,
   parameter int DEPTH  = 108,
   parameter int ADDR_W = 7
) (
   input  logic              clock,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [WORD_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [WORD_W-1:0] read_data
);

   logic [WORD_W-1:0] r_mem [DEPTH];

   // No reset on the array so it can map onto block RAM / LUT RAM.
   always_ff @(posedge clock) begin
      if (write_en) begin
         r_mem[write_addr] <= write_data;
      end
   end

   assign read_data = r_mem[read_addr];

endmodule
`default_nettype wire

// File: rtl/csc_pingpong_data_spad.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : csc_pingpong_data_spad                                 |
// | Double-buffered CSC {data,count} scratchpad: one bank fills      |
// | while the other is consumed. Optional CSC_SPAD_OVF_FLAG_EN adds  |
// | sticky overflow and fill_count outputs.                          |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module csc_pingpong_data_spad
   import pe_spad_pkg::*;
#(
   parameter  int DATA_W = C_DATA_W,
   parameter  int CNT_W  = C_CNT_W,
   parameter  int DEPTH  = 108,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int WORD_W = word_w(DATA_W, CNT_W)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   input  logic [WORD_W-1:0] data_in,
   input  logic              write_en,
   output logic              write_fin,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] read_idx,
   input  logic              read_idx_en,
   input  logic              index_inc,
   output logic [ADDR_W-1:0] column_num,
   output logic [WORD_W-1:0] data_out,
   output logic              read_fin,
`ifdef CSC_SPAD_OVF_FLAG_EN
   output logic              overflow,
   output logic [ADDR_W:0]   fill_count,
`endif
   output logic [1:0]        bank_valid,
   output logic              wr_bank,
   output logic              rd_bank
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_column_num;
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [1:0]        r_bank_valid;

   logic [WORD_W-1:0] w_bank_rdata [2];
   logic              w_shake;
   logic              w_is_term;
   logic              w_wr_close;
   logic              w_rd_valid;
   logic              w_read_fin;
   logic [1:0]        w_bank_valid_nxt;

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         localparam logic c_sel = 1'(b);
         spad_bank_mem #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
         ) u_mem (
            .clock      (clock),
            .write_en   (w_shake && (r_wr_bank == c_sel)),
            .write_addr (r_wr_addr),
            .write_data (data_in),
            .read_addr  (r_rd_addr),
            .read_data  (w_bank_rdata[b])
         );
      end
   endgenerate

   assign w_rd_valid    = r_bank_valid[r_rd_bank];
   assign data_out      = w_rd_valid ? w_bank_rdata[r_rd_bank] : '0;
   assign data_in_ready = ~r_bank_valid[r_wr_bank];
   assign w_shake       = data_in_valid & data_in_ready & write_en;
   assign w_is_term     = (data_in == '0);
   assign w_wr_close    = w_shake & (w_is_term | (r_wr_addr == c_last_addr));
   assign write_fin     = w_shake & w_is_term;
   assign w_read_fin    = index_inc & w_rd_valid & (data_out == '0) & ~read_idx_en;
   assign read_fin      = w_read_fin;

   // A closing write and a releasing read always target different banks.
   always_comb begin
      w_bank_valid_nxt = r_bank_valid;
      if (w_wr_close) begin
         w_bank_valid_nxt[r_wr_bank] = 1'b1;
      end
      if (w_read_fin) begin
         w_bank_valid_nxt[r_rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_addr    <= '0;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_bank_valid <= '0;
      end else begin
         r_bank_valid <= w_bank_valid_nxt;
         if (w_shake) begin
            r_wr_addr <= w_wr_close ? '0 : r_wr_addr + 1'b1;
         end
         if (w_wr_close) begin
            r_wr_bank <= ~r_wr_bank;
         end
         if (w_read_fin) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_column_num <= '0;
         r_rd_addr    <= '0;
      end else begin
         if (read_idx_en) begin
            r_column_num <= read_idx;
         end else if (index_inc && w_rd_valid) begin
            if (w_read_fin || (r_column_num == c_last_addr)) begin
               r_column_num <= '0;
            end else begin
               r_column_num <= r_column_num + 1'b1;
            end
         end
         if (w_read_fin) begin
            r_rd_addr <= '0;
         end else if (read_en) begin
            r_rd_addr <= r_column_num;
         end
      end
   end

`ifdef CSC_SPAD_OVF_FLAG_EN
   logic            r_overflow;
   logic [ADDR_W:0] r_fill_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow   <= 1'b0;
         r_fill_count <= '0;
      end else if (w_wr_close) begin
         if (!w_is_term) begin
            r_overflow <= 1'b1;
         end
         r_fill_count <= {1'b0, r_wr_addr} + (ADDR_W+1)'(1);
      end
   end

   assign overflow   = r_overflow;
   assign fill_count = r_fill_count;
`endif

   assign column_num = r_column_num;
   assign bank_valid = r_bank_valid;
   assign wr_bank    = r_wr_bank;
   assign rd_bank    = r_rd_bank;

endmodule
`default_nettype wire

// File: doc/csc_pingpong_data_spad.md
Name: csc_pingpong_data_spad

Overview:
Parametrised, double-buffered successor to the PE's CSC data scratchpad. It stores CSC-encoded {data, count} words: iacts for CONV, weights for DW-CONV/FC. Two banks let the GLB/router fill the next column set while the MAC datapath consumes the current one. Sits inside each PE and is driven by the PE control FSM.

Parameters:
DATA_W, 8, signed data field width (INT-8).
CNT_W, 4, count/row-index field width; up to 2^CNT_W rows.
DEPTH, 108, words per bank.
ADDR_W, derived localparam $clog2(DEPTH), address/column index width.
WORD_W, derived localparam DATA_W+CNT_W; word layout {data[WORD_W-1:CNT_W], count[CNT_W-1:0]}.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
data_in_valid  in  1  write word valid.
data_in_ready  out  1  write bank free.
data_in  in  WORD_W  CSC word; all-zero word is the terminator.
write_en  in  1  write-phase enable from PE control.
write_fin  out  1  pulse: terminator accepted.
read_en  in  1  latch column_num into the read address.
read_idx  in  ADDR_W  direct column index.
read_idx_en  in  1  load column_num from read_idx.
index_inc  in  1  advance column_num.
column_num  out  ADDR_W  current read column pointer.
data_out  out  WORD_W  word at the registered read address in the read bank.
read_fin  out  1  pulse: terminator consumed, read bank released.
bank_valid  out  2  per-bank full flag.
wr_bank  out  1  bank currently being filled.
rd_bank  out  1  bank currently being read.

Behaviour:
- Reset, asynchronous: column_num, read addr, write addr, wr_bank, rd_bank and bank_valid go to 0. Memory array is not reset.
- data_out = 0 whenever bank_valid[rd_bank]=0, so the reset value is 0. Otherwise data_out = mem[rd_bank][rd_addr], combinational from the registered address.
- data_in_ready = ~bank_valid[wr_bank]. shake = data_in_valid & data_in_ready & write_en.
- On shake: mem[wr_bank][wr_addr] <= data_in.
  - Close condition: data_in==0 or wr_addr==DEPTH-1.
  - If close: wr_addr<=0, bank_valid[wr_bank]<=1, wr_bank toggles.
  - Else: wr_addr increments.
- write_fin = shake & (data_in==0), combinational.
- Closing at DEPTH-1 on a non-zero word is an overflow. The bank still closes; no terminator is stored.
- Read pointer priority:
  - read_idx_en: column_num<=read_idx, always accepted.
  - else index_inc & bank_valid[rd_bank]: if read_fin then column_num<=0, else column_num+1, wrapping DEPTH-1 -> 0.
  - index_inc is ignored while the read bank is empty.
- rd_addr <= column_num on read_en, so one-cycle address latency. rd_addr <= 0 on read_fin.
- read_fin = index_inc & bank_valid[rd_bank] & (data_out==0) & ~read_idx_en. On read_fin: bank_valid[rd_bank]<=0, rd_bank toggles.
- Simultaneous events:
  - A write-close and a read_fin in the same cycle update distinct bank flags independently; both take effect.
  - A bank released by read_fin is not writable until the next cycle.
- Both banks full: data_in_ready=0 and writes stall with no loss.

Optional Feature:
CSC_SPAD_OVF_FLAG_EN.
- Defined: adds output overflow (1b). It sets sticky on an overflow close and clears only on reset. It also adds output fill_count (ADDR_W+1 bits): the number of words stored in the most recently closed bank.
- Undefined: neither port exists. Overflow closes the bank silently; all other behaviour is identical.

Decomposition:
- Shared package pe_spad_pkg: DATA_W/CNT_W defaults, the WORD_W function, and the terminator constant (all-zero word). Shared with the address spad and psum spad.
- One natural sub-module: spad_bank_mem, a single-bank DEPTH×WORD_W array with sync write and async read. It is instantiated twice, which keeps later BRAM mapping local to that sub-module.

Test Plan:
1. Reset, then write 0x123, 0x456, 0x000 with write_en=1 -> write_fin pulses on the 3rd word; bank_valid=01, wr_bank=1; data_out=0 before read_en.
2. Read that bank: read_en, then index_inc ×3 -> data_out 0x123, 0x456, 0x000. read_fin pulses on the 3rd index_inc; column_num=0, bank_valid=00, rd_bank=1.
3. Fill bank0 and bank1, then offer a 3rd word -> data_in_ready=0 and the word is not written. After read_fin on bank0, ready=1 the next cycle and the write goes to bank0.
4. Same-cycle write-close of bank1 and read_fin of bank0 -> bank_valid goes 01 -> 10 in one edge, with no lost word.
5. Write DEPTH (108) non-zero words -> the bank closes after word 108 with write_fin=0. With CSC_SPAD_OVF_FLAG_EN: overflow=1, fill_count=108.
6. Assert read_idx_en with read_idx=5 together with index_inc on a terminator word -> column_num=5, no read_fin. Assert reset mid-write -> all flags 0 immediately, without waiting for a clock edge.
